piece_controller: RTL and testbench

//  Active-piece FSM that drives the board module's piece interface: current_x/y/piece/rotation and place_piece.

---
 rtl/piece_controller.sv | 160 ++++++++++++++++
 tb/tb_piece_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_controller.sv
// Active-piece controller: presents candidate positions to the board, samples the
// collision flag one cycle later, then commits or reverts; also spawns, drops and places.
module piece_controller #(
  parameter int SPAWN_X = 3,
  parameter int SPAWN_Y = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_drop,
  input  logic       tick,
  input  logic       collision,
  output logic [3:0] current_x,
  output logic [4:0] current_y,
  output logic [2:0] current_piece,
  output logic [1:0] current_rotation,
  output logic       place_piece,
  output logic       ready,
  output logic       game_over
);

  // state     | meaning
  // S_SPAWN   | load spawn position and next piece type
  // S_SPAWN_CHK | board checks the freshly spawned piece
  // S_READY   | idle, accepting one request
  // S_PROBE   | candidate presented, board verdict pending
  // S_DROP    | hard drop, moving down every cycle until blocked
  // S_PLACE   | one-cycle place strobe with last-good position
  // S_OVER    | spawn was blocked; frozen until reset
  typedef enum logic [2:0] {
    S_SPAWN, S_SPAWN_CHK, S_READY, S_PROBE, S_DROP, S_PLACE, S_OVER
  } state_t;

  localparam logic [3:0] SPAWN_X_V = 4'(SPAWN_X);
  localparam logic [4:0] SPAWN_Y_V = 5'(SPAWN_Y);

  state_t     r_state, w_nxt_state;
  logic [3:0] r_x, w_nxt_x, r_lg_x, w_nxt_lg_x;
  logic [4:0] r_y, w_nxt_y, r_lg_y, w_nxt_lg_y;
  logic [1:0] r_rot, w_nxt_rot, r_lg_rot, w_nxt_lg_rot;
  logic [2:0] r_piece, w_nxt_piece;
  logic [2:0] r_piece_ctr, w_nxt_piece_ctr;
  logic       r_tick_pend, w_nxt_tick_pend;
  logic       r_down, w_nxt_down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_SPAWN;
      r_x         <= SPAWN_X_V;
      r_y         <= SPAWN_Y_V;
      r_rot       <= 2'd0;
      r_piece     <= 3'd0;
      r_lg_x      <= SPAWN_X_V;
      r_lg_y      <= SPAWN_Y_V;
      r_lg_rot    <= 2'd0;
      r_piece_ctr <= 3'd0;
      r_tick_pend <= 1'b0;
      r_down      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_x         <= w_nxt_x;
      r_y         <= w_nxt_y;
      r_rot       <= w_nxt_rot;
      r_piece     <= w_nxt_piece;
      r_lg_x      <= w_nxt_lg_x;
      r_lg_y      <= w_nxt_lg_y;
      r_lg_rot    <= w_nxt_lg_rot;
      r_piece_ctr <= w_nxt_piece_ctr;
      r_tick_pend <= w_nxt_tick_pend;
      r_down      <= w_nxt_down;
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_x         = r_x;
    w_nxt_y         = r_y;
    w_nxt_rot       = r_rot;
    w_nxt_piece     = r_piece;
    w_nxt_lg_x      = r_lg_x;
    w_nxt_lg_y      = r_lg_y;
    w_nxt_lg_rot    = r_lg_rot;
    w_nxt_down      = r_down;
    w_nxt_piece_ctr = (r_piece_ctr == 3'd6) ? 3'd0 : r_piece_ctr + 3'd1;
    // Ticks outside READY are remembered; buttons outside READY are simply lost.
    w_nxt_tick_pend = r_tick_pend |
                      (tick & (r_state != S_READY) & (r_state != S_OVER));

    case (r_state)
      S_SPAWN: begin
        w_nxt_x     = SPAWN_X_V;
        w_nxt_y     = SPAWN_Y_V;
        w_nxt_rot   = 2'd0;
        w_nxt_piece = r_piece_ctr;
        w_nxt_state = S_SPAWN_CHK;
      end
      S_SPAWN_CHK: w_nxt_state = collision ? S_OVER : S_READY;
      S_READY: begin
        w_nxt_lg_x   = r_x;
        w_nxt_lg_y   = r_y;
        w_nxt_lg_rot = r_rot;
        if (btn_drop) begin
          w_nxt_y     = r_y + 5'd1;
          w_nxt_state = S_DROP;
        end else if (tick || r_tick_pend) begin
          w_nxt_y         = r_y + 5'd1;
          w_nxt_down      = 1'b1;
          w_nxt_tick_pend = 1'b0;
          w_nxt_state     = S_PROBE;
        end else if (btn_rotate) begin
          w_nxt_rot   = r_rot + 2'd1;
          w_nxt_down  = 1'b0;
          w_nxt_state = S_PROBE;
        end else if (btn_left) begin
          w_nxt_x     = r_x - 4'd1;
          w_nxt_down  = 1'b0;
          w_nxt_state = S_PROBE;
        end else if (btn_right) begin
          w_nxt_x     = r_x + 4'd1;
          w_nxt_down  = 1'b0;
          w_nxt_state = S_PROBE;
        end
      end
      S_PROBE: begin
        w_nxt_state = S_READY;
        if (collision) begin
          w_nxt_x   = r_lg_x;
          w_nxt_y   = r_lg_y;
          w_nxt_rot = r_lg_rot;
          if (r_down) w_nxt_state = S_PLACE;
        end
      end
      S_DROP: begin
        if (collision) begin
          w_nxt_x     = r_lg_x;
          w_nxt_y     = r_lg_y;
          w_nxt_rot   = r_lg_rot;
          w_nxt_state = S_PLACE;
        end else begin
          w_nxt_lg_y = r_y;
          w_nxt_y    = r_y + 5'd1;
        end
      end
      S_PLACE: w_nxt_state = S_SPAWN;
      S_OVER:  w_nxt_state = S_OVER;
      default: w_nxt_state = S_SPAWN;
    endcase
  end

  assign current_x        = r_x;
  assign current_y        = r_y;
  assign current_piece    = r_piece;
  assign current_rotation = r_rot;
  assign place_piece      = (r_state == S_PLACE);
  assign ready            = (r_state == S_READY);
  assign game_over        = (r_state == S_OVER);

endmodule

// File: tb/tb_piece_controller.sv
// Bench for piece_controller: a simple board model drives collision, a position-level
// reference model predicts ready/place/over events, and a monitor compares them.
module tb_piece_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_rotate = 1'b0;
  logic       btn_drop = 1'b0, tick = 1'b0;
  logic       collision;
  logic [3:0] current_x;
  logic [4:0] current_y;
  logic [2:0] current_piece;
  logic [1:0] current_rotation;
  logic       place_piece, ready, game_over;

  piece_controller #(.SPAWN_X(3), .SPAWN_Y(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate),
    .btn_drop(btn_drop), .tick(tick), .collision(collision),
    .current_x(current_x), .current_y(current_y), .current_piece(current_piece),
    .current_rotation(current_rotation), .place_piece(place_piece),
    .ready(ready), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Board: columns 0..9, rows 0..ylim; force flags emulate an occupied board.
  bit force_all = 1'b0;
  bit force_one = 1'b0;
  int ylim = 19;
  assign collision = force_all | force_one | (current_x > 4'd9) | (int'(current_y) > ylim);

  int edge_cnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;

  localparam logic [1:0] EV_READY = 2'd0, EV_PLACE = 2'd1, EV_OVER = 2'd2;
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] x;
    logic [4:0] y;
    logic [2:0] p;
    logic [1:0] r;
  } ev_t;
  ev_t exp_q[$];

  int mx, my, mr, mp;

  function automatic bit board_hit(input int x, input int y);
    return force_all || (x > 9) || (y > ylim);
  endfunction

  task automatic push_ev(input logic [1:0] kind);
    ev_t e;
    e.kind = kind; e.x = 4'(mx); e.y = 5'(my); e.p = 3'(mp); e.r = 2'(mr);
    exp_q.push_back(e);
  endtask

  task automatic model_spawn(input int piece);
    mx = 3; my = 0; mr = 0; mp = piece;
    if (board_hit(3, 0)) push_ev(EV_OVER);
    else                 push_ev(EV_READY);
  endtask

  // mask: [4] drop, [3] tick, [2] rotate, [1] left, [0] right; n = edge that samples it
  task automatic model_cmd(input logic [4:0] mask, input int n, input bit frc);
    int nx, yf;
    bit hit;
    if (mask[4]) begin
      yf = my;
      hit = frc || board_hit(mx, yf + 1);
      while (!hit) begin
        yf++;
        hit = board_hit(mx, yf + 1);
      end
      nx = yf - my;
      my = yf;
      push_ev(EV_PLACE);
      model_spawn((n + nx + 2) % 7);
    end else if (mask[3]) begin
      if (frc || board_hit(mx, my + 1)) begin
        push_ev(EV_PLACE);
        model_spawn((n + 2) % 7);
      end else begin
        my++;
        push_ev(EV_READY);
      end
    end else if (mask[2]) begin
      if (!frc) mr = (mr + 1) % 4;
      push_ev(EV_READY);
    end else if (mask[1] || mask[0]) begin
      nx = mask[1] ? (mx + 15) % 16 : (mx + 1) % 16;
      if (!(frc || board_hit(nx, my))) mx = nx;
      push_ev(EV_READY);
    end
  endtask

  task automatic check_ev(input logic [1:0] kind, input string name);
    ev_t act, exp;
    act.kind = kind; act.x = current_x; act.y = current_y;
    act.p = current_piece; act.r = current_rotation;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: unexpected event got %h, nothing expected", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        miscompares++;
        $display("FAIL %s: got kind=%0d x=%0d y=%0d p=%0d r=%0d expected kind=%0d x=%0d y=%0d p=%0d r=%0d",
                 name, act.kind, act.x, act.y, act.p, act.r,
                 exp.kind, exp.x, exp.y, exp.p, exp.r);
      end
    end
  endtask

  logic prev_ready = 1'b0, prev_place = 1'b0, prev_go = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ready = 1'b0; prev_place = 1'b0; prev_go = 1'b0;
    end else begin
      if (place_piece) begin
        check_ev(EV_PLACE, "place");
        vectors++;
        if (prev_place) begin
          miscompares++;
          $display("FAIL place_width: place_piece high on consecutive cycles, required single pulse");
        end
      end
      if (ready && !prev_ready) check_ev(EV_READY, "ready");
      if (game_over && !prev_go) check_ev(EV_OVER, "over");
      prev_ready = ready; prev_place = place_piece; prev_go = game_over;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_btns();
    {btn_drop, tick, btn_rotate, btn_left, btn_right} = 5'b0;
  endtask

  task automatic wait_ready();
    int i;
    i = 0;
    while (!ready && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: ready=0 after 200 cycles, required 1");
    end
  endtask

  task automatic do_reset(input bit expect_go);
    rst_n = 1'b0;
    force_one = 1'b0;
    clear_btns();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", current_x, 3);
    chk("rst_y", current_y, 0);
    chk("rst_piece", current_piece, 0);
    chk("rst_rot", current_rotation, 0);
    chk("rst_place", place_piece, 0);
    chk("rst_ready", ready, 0);
    chk("rst_over", game_over, 0);
    rst_n = 1'b1;
    model_spawn(0);
    @(posedge clk); #1;
    chk("ready_edge1", ready, 0);
    @(posedge clk); #1;
    chk("ready_edge2", ready, expect_go ? 0 : 1);
    chk("over_edge2", game_over, expect_go ? 1 : 0);
  endtask

  task automatic issue(input logic [4:0] mask, input bit frc, input bit tip);
    int n;
    wait_ready();
    n = edge_cnt + 1;
    model_cmd(mask, n, frc);
    {btn_drop, tick, btn_rotate, btn_left, btn_right} = mask;
    @(posedge clk); #1;
    clear_btns();
    force_one = frc;
    tick = tip;
    if (tip) model_cmd(5'b01000, n + 2, 1'b0);
    @(posedge clk); #1;
    force_one = 1'b0;
    tick = 1'b0;
    if (tip) begin
      wait_ready();
      @(posedge clk); #1;
    end
    wait_ready();
  endtask

  initial begin
    logic [4:0] mask;
    bit frc, tip;

    do_reset(1'b0);

    issue(5'b00010, 1'b0, 1'b0);
    issue(5'b00010, 1'b1, 1'b0);
    repeat (4) issue(5'b00100, 1'b0, 1'b0);
    repeat (3) issue(5'b01000, 1'b0, 1'b0);
    issue(5'b01000, 1'b1, 1'b0);

    ylim = 17;
    issue(5'b10000, 1'b0, 1'b0);
    ylim = 19;

    issue(5'b00010, 1'b0, 1'b1);
    issue(5'b00111, 1'b0, 1'b0);
    issue(5'b01101, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      if (i % 25 == 0) ylim = $urandom_range(6, 19);
      mask = 5'($urandom_range(1, 31));
      if (mask[4]) mask[3] = 1'b0;
      frc = ($urandom_range(0, 4) == 0);
      tip = (!mask[4] && !mask[3] && $urandom_range(0, 5) == 0);
      issue(mask, frc, tip);
    end
    ylim = 19;

    // Reset in the middle of a hard drop.
    wait_ready();
    @(negedge clk);
    #1;
    btn_drop = 1'b1;
    @(posedge clk); #1;
    btn_drop = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("drop_rst_x", current_x, 3);
    chk("drop_rst_y", current_y, 0);
    chk("drop_rst_place", place_piece, 0);
    chk("drop_rst_ready", ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_rst_hold_place", place_piece, 0);
    end

    force_all = 1'b1;
    do_reset(1'b1);
    for (int i = 0; i < 30; i++) begin
      {btn_drop, tick, btn_rotate, btn_left, btn_right} = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      chk("over_place", place_piece, 0);
      chk("over_sticky", game_over, 1);
    end
    clear_btns();
    rst_n = 1'b0;
    #1;
    chk("over_cleared", game_over, 0);
    force_all = 1'b0;
    do_reset(1'b0);
    issue(5'b00001, 1'b0, 1'b0);
    @(negedge clk); #1;

    chk("leftover_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
